gray_stream_decoder: RTL
========================

GRAY_STREAM_DECODER -- requirements
Module: gray_stream_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the Gray/binary code width; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream Gray code is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a code this cycle.
REQ-006 The block SHALL have port in_gray, input, WIDTH bits: the Gray-coded input value.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the output word is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output word.
REQ-009 The block SHALL have port out_bin, output, WIDTH bits: the decoded binary value.
REQ-010 The block SHALL have port out_step_err, output, 1 bit: this word is not a single-bit step from the previous accepted code.
REQ-011 The block SHALL have port out_dir, output, 2 bits: step direction; 00 none/first, 01 up, 10 down, 11 invalid step.
REQ-012 The block SHALL have port clr_err, input, 1 bit: synchronous clear of err_count.
REQ-013 The block SHALL have port err_count, output, 8 bits: saturating count of step errors.

Function
REQ-014 A transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1.
REQ-015 The handshake SHALL be a one-entry output register: in_ready = !out_valid || out_ready, combinational; there is no other path from input to output.
REQ-016 Latency SHALL be one cycle: a code accepted at edge N is presented on out_* after edge N.
REQ-017 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 The decode SHALL be: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0.
REQ-019 The block SHALL implement a two-state FSM:
- FIRST: no previous code is held; reset state.
- TRACK: prev_gray and prev_bin are held.
REQ-020 In FIRST, an accepted code SHALL set out_step_err=0 and out_dir=00, store prev_gray/prev_bin, and move the FSM to TRACK.
REQ-021 In TRACK, an accepted code SHALL produce out_step_err=1 exactly when popcount(in_gray XOR prev_gray) != 1.
- This includes a repeated identical code (popcount 0).
REQ-022 In TRACK, out_dir SHALL be:
- 01 if new_bin == prev_bin+1 mod 2^WIDTH;
- 10 if new_bin == prev_bin-1 mod 2^WIDTH;
- 11 if out_step_err=1.
REQ-023 Wrap-around SHALL count as a legal step: prev all-ones to new 0 is up; prev 0 to new all-ones is down.
REQ-024 prev_gray/prev_bin SHALL update on every accepted code, including erroneous ones.
REQ-025 err_count SHALL increment by 1 on each accepted code with a step error, and SHALL saturate at 255.
REQ-026 If clr_err=1 in the same cycle as an error increment, err_count SHALL become 0 (clear wins).
REQ-027 in_gray SHALL be ignored when no transfer occurs, and prev state SHALL NOT change.

Reset
REQ-028 While rst=0, the block SHALL force:
- out_valid=0, out_bin=0, out_step_err=0, out_dir=00, err_count=0;
- prev_gray=0, prev_bin=0, FSM=FIRST.
REQ-029 Reset mid-operation SHALL discard any pending output word; the first code after release SHALL be treated as FIRST.
REQ-030 After reset release, in_ready SHALL be 1 (out_valid=0).

Verification
REQ-031 Sweep: out_ready=1, feed Gray 0000,0001,0011,...,1000 (bin 0..15), one code per cycle.
- out_bin = 0..15, each one cycle after input.
- out_dir = 00 for the first word, then 01; err_count = 0.
REQ-032 Wrap: after the sweep, feed 0000.
- out_bin=0, out_dir=01, out_step_err=0.
- Then feed 1000: out_bin=15, out_dir=10.
REQ-033 Jump error: feed 0000 then 0011.
- Second word: out_bin=2, out_step_err=1, out_dir=11, err_count=1.
- Repeating 0011 gives a second error: err_count=2.
REQ-034 Backpressure: hold out_ready=0 with 3 codes offered.
- Exactly one word is accepted; in_ready=0; out_* stable.
- Releasing out_ready drains the codes in order with no loss or duplication.
REQ-035 Saturation/clear: inject 300 step errors -> err_count=255.
- clr_err coincident with a further error -> err_count=0.
REQ-036 Reset mid-stream: assert rst while out_valid=1 -> out_valid=0 immediately.
- After release, feed 0110 -> out_bin=4, out_dir=00, out_step_err=0.

Source files
------------

// File: rtl/gray_stream_decoder.sv
// Gray-code stream decoder with a one-entry output register,
// step checking against the previous code and a saturating error count.
`timescale 1ns/1ps
module gray_stream_decoder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_step_err,
    output logic [1:0]       out_dir,
    input  logic             clr_err,
    output logic [7:0]       err_count
);

    typedef enum logic {
        FIRST,
        TRACK
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] prev_bin;
    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] diff;
    logic             accept;
    logic             single;
    logic             step_err;
    logic [1:0]       dir;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign diff     = in_gray ^ prev_gray;
    assign single   = (diff != '0) && ((diff & (diff - ONE)) == '0);

    // Gray to binary: prefix XOR from the MSB down
    always_comb begin
        new_bin = '0;
        new_bin[WIDTH-1] = in_gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            new_bin[i] = new_bin[i+1] ^ in_gray[i];
        end
    end

    // Next state and step classification of the offered code
    always_comb begin
        state_nxt = state;
        step_err  = 1'b0;
        dir       = 2'b00;
        unique case (state)
            FIRST: begin
                if (accept) begin
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                step_err = !single;
                unique case (1'b1)
                    !single:                   dir = 2'b11;
                    new_bin == prev_bin + ONE: dir = 2'b01;
                    new_bin == prev_bin - ONE: dir = 2'b10;
                    default:                   dir = 2'b11;
                endcase
            end
            default: state_nxt = FIRST;
        endcase
    end

    // FSM state and previous-code tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FIRST;
            prev_gray <= '0;
            prev_bin  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                prev_gray <= in_gray;
                prev_bin  <= new_bin;
            end
        end
    end

    // One-entry output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_bin      <= '0;
            out_step_err <= 1'b0;
            out_dir      <= 2'b00;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_bin      <= new_bin;
            out_step_err <= step_err;
            out_dir      <= dir;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating error counter; clear takes priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= 8'd0;
        end else if (clr_err) begin
            err_count <= 8'd0;
        end else if (accept && step_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule
